// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for bin_to_bcd_seq: operand in, BCD result out.
// The sign signal exists only when BIN_TO_BCD_SIGNED_EN is defined.
interface bin_to_bcd_seq_if #(
  parameter int BIN_WIDTH  = 16,
  parameter int BCD_DIGITS = (BIN_WIDTH*3)/10+1
);
  logic                    in_valid;
  logic                    in_ready;
  logic [BIN_WIDTH-1:0]    bin;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic                    ovf;
  logic                    busy;
`ifdef BIN_TO_BCD_SIGNED_EN
  logic                    sign;

  modport master (output in_valid, bin, out_ready,
                  input  in_ready, out_valid, bcd, ovf, busy, sign);
  modport slave  (input  in_valid, bin, out_ready,
                  output in_ready, out_valid, bcd, ovf, busy, sign);
`else
  modport master (output in_valid, bin, out_ready,
                  input  in_ready, out_valid, bcd, ovf, busy);
  modport slave  (input  in_valid, bin, out_ready,
                  output in_ready, out_valid, bcd, ovf, busy);
`endif
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Serial double-dabble binary-to-BCD converter, one add-3/shift step per clock.
// Optional macro BIN_TO_BCD_SIGNED_EN: two's-complement operand, magnitude plus sign.

module bin_to_bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

module bin_to_bcd_seq #(
  parameter int BIN_WIDTH  = 16,
  parameter int BCD_DIGITS = (BIN_WIDTH*3)/10+1
) (
  input  logic             clk,
  input  logic             rst,
  bin_to_bcd_seq_if.slave  bus
);
  localparam int BCDW = 4*BCD_DIGITS;
  localparam int SRW  = BCDW + BIN_WIDTH;
  localparam int CW   = $clog2(BIN_WIDTH+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [SRW-1:0]   sr_q, sr_d;
  logic [SRW-1:0]   corr;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [BCDW-1:0]  res_q, res_d;
  logic             res_ovf_q, res_ovf_d;
  logic [BIN_WIDTH-1:0] load;
  logic             neg;
  logic             sgn_q, sgn_d;
  logic             res_sgn_q, res_sgn_d;

`ifdef BIN_TO_BCD_SIGNED_EN
  // One extra bit so that the most negative operand's magnitude is exact.
  logic [BIN_WIDTH:0] ext, mag;
  always_comb begin
    ext  = {bus.bin[BIN_WIDTH-1], bus.bin};
    mag  = ext[BIN_WIDTH] ? (~ext + (BIN_WIDTH+1)'(1)) : ext;
    load = mag[BIN_WIDTH-1:0];
    neg  = bus.bin[BIN_WIDTH-1];
  end
  assign bus.sign = res_sgn_q;
`else
  assign load = bus.bin;
  assign neg  = 1'b0;
`endif

  // Binary field passes through; every BCD digit gets its add-3 correction.
  assign corr[BIN_WIDTH-1:0] = sr_q[BIN_WIDTH-1:0];
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dig
    bin_to_bcd_add3 u_add3 (
      .d_i (sr_q[BIN_WIDTH+4*g +: 4]),
      .d_o (corr[BIN_WIDTH+4*g +: 4])
    );
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sgn_d     = sgn_q;
    res_d     = res_q;
    res_ovf_d = res_ovf_q;
    res_sgn_d = res_sgn_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d    = {{BCDW{1'b0}}, load};
          cnt_d   = '0;
          ovf_d   = 1'b0;
          sgn_d   = neg;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {corr[SRW-2:0], 1'b0};
        ovf_d = ovf_q | corr[SRW-1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BIN_WIDTH-1)) begin
          // Result registers only change here, so bcd/ovf/sign hold through IDLE.
          res_d     = sr_d[SRW-1 -: BCDW];
          res_ovf_d = ovf_d;
          res_sgn_d = sgn_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sgn_q     <= 1'b0;
      res_q     <= '0;
      res_ovf_q <= 1'b0;
      res_sgn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sgn_q     <= sgn_d;
      res_q     <= res_d;
      res_ovf_q <= res_ovf_d;
      res_sgn_q <= res_sgn_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.bcd       = res_q;
  assign bus.ovf       = res_ovf_q;
endmodule
